// File: rtl/mul_32_seq.sv
// Sequential 32x32 signed radix-2 shift-add multiplier; 34-cycle start-to-done, start accepted in IDLE/DONE.
// Define MUL_EARLY_EXIT_EN to leave CALC as soon as the remaining multiplier bits are all zero.
module mul_32_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        done,
  output logic [63:0] Y,
  output logic        Vt
);

  typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;

  state_t      state, state_nxt;
  logic [63:0] mcand;
  logic [63:0] acc;
  logic [31:0] mplier;
  logic [4:0]  cnt;
  logic        neg;

  logic        accept;
  logic        calc_last;
  logic [31:0] a_mag, b_mag;
  logic [63:0] y_nxt;

  assign accept = start && ((state == IDLE) || (state == DONE));
  // 0x80000000 negates to itself, which is the correct unsigned magnitude
  assign a_mag  = A[31] ? (~A + 32'd1) : A;
  assign b_mag  = B[31] ? (~B + 32'd1) : B;
  assign y_nxt  = neg ? (~acc + 64'd1) : acc;

`ifdef MUL_EARLY_EXIT_EN
  assign calc_last = (cnt == 5'd31) || (mplier[31:1] == 31'd0);
`else
  assign calc_last = (cnt == 5'd31);
`endif

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (calc_last) state_nxt = SIGN;
      SIGN:    state_nxt = DONE;
      DONE:    state_nxt = start ? CALC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      CALC, SIGN: busy = 1'b1;
      DONE:       done = 1'b1;
      default:    ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      mcand  <= 64'd0;
      acc    <= 64'd0;
      mplier <= 32'd0;
      cnt    <= 5'd0;
      neg    <= 1'b0;
      Y      <= 64'd0;
      Vt     <= 1'b0;
    end else begin
      if (accept) begin
        mcand  <= {32'd0, a_mag};
        mplier <= b_mag;
        neg    <= A[31] ^ B[31];
        acc    <= 64'd0;
        cnt    <= 5'd0;
      end else if (state == CALC) begin
        if (mplier[0]) acc <= acc + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + 5'd1;
      end
      // Result registers change only on the edge entering DONE
      if (state == SIGN) begin
        Y  <= y_nxt;
        Vt <= (y_nxt[63:32] != {32{y_nxt[31]}});
      end
    end
  end

endmodule

// File: tb/tb_mul_32_seq.sv
// Scoreboard bench for mul_32_seq: expected products and done cycles queued at issue, checked by a monitor.
module tb_mul_32_seq;

  typedef struct {
    logic [63:0] y;
    logic        vt;
    int          cyc;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] A, B;
  logic        busy, done, Vt;
  logic [63:0] Y;

  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  exp_t q[$];
  logic [63:0] last_y;
  logic        last_vt;

  mul_32_seq dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .Y     (Y),
    .Vt    (Vt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
  endtask

  // Reference: plain signed 64-bit product, range test, and latency from the magnitude of B
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input int c0);
    exp_t    e;
    longint  p;
    p    = longint'($signed(a)) * longint'($signed(b));
    e.y  = 64'(p);
    e.vt = (p > 64'sd2147483647) || (p < -64'sd2147483648);
`ifdef MUL_EARLY_EXIT_EN
    begin
      logic [31:0] m;
      int          bl;
      m  = b[31] ? -b : b;
      bl = 0;
      for (int i = 0; i < 32; i++) if (m[i]) bl = i + 1;
      e.cyc = c0 + 1 + ((bl < 1) ? 1 : bl) + 1;
    end
`else
    e.cyc = c0 + 1 + 33;
`endif
    return e;
  endfunction

  // Monitor: every done pulse must match the head of the scoreboard
  always @(negedge clk) begin
    if (reset && done) begin
      if (q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_done: got done=1 expected no pending op (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("Y", Y, e.y);
        chk("Vt", 64'(Vt), 64'(e.vt));
        chk("done_cycle", 64'(cyc), 64'(e.cyc));
        chk("busy_at_done", 64'(busy), 64'd0);
      end
    end
  end

  // Call right after a negedge; start is sampled on the following posedge
  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e = model(a, b, cyc);
    q.push_back(e);
    last_y  = e.y;
    last_vt = e.vt;
    start = 1'b1;
    A = a;
    B = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain(input bit toggle);
    for (int i = 0; i < 200 && q.size() != 0; i++) begin
      if (toggle) begin
        A = $urandom;
        B = $urandom;
        start = (i == 9);
      end
      @(negedge clk);
    end
    start = 1'b0;
    if (q.size() != 0) begin
      n_chk++;
      $display("FAIL drain_timeout: got %0d pending results expected 0", q.size());
      q.delete();
    end
    chk("busy_after_done", 64'(busy), 64'd0);
    @(negedge clk);
    chk("Y_held", Y, last_y);
    chk("Vt_held", 64'(Vt), 64'(last_vt));
  endtask

  logic [31:0] da[7] = '{32'd7, 32'h80000000, 32'h7FFFFFFF, 32'd0, 32'hFFFFFFFF, 32'd100, 32'd100};
  logic [31:0] db[7] = '{32'hFFFFFFFD, 32'h80000000, 32'd2, 32'hFFFFFFFB, 32'hFFFFFFFF, 32'd3, 32'd0};

  initial begin
    reset = 1'b0;
    start = 1'b0;
    A = 32'd0;
    B = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_Y", Y, 64'd0);
    chk("rst_Vt", 64'(Vt), 64'd0);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      issue(da[i], db[i]);
      chk("busy_running", 64'(busy), 64'd1);
      drain(1'b0);
    end

    for (int i = 0; i < 16; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) b = -b;
      issue(a, b);
      drain(1'b0);
    end

    // Operands toggled every cycle and a second start at edge 10 must be ignored
    issue(32'h12345678, 32'hC0000001);
    drain(1'b1);
    repeat (40) @(negedge clk);

    // Back-to-back: second start accepted during the DONE cycle
    issue(32'hFFFF0001, 32'd12345);
    for (int i = 0; i < 100 && !done; i++) @(negedge clk);
    if (!done) begin
      n_chk++;
      $display("FAIL b2b_wait: got done=0 expected done within 100 cycles");
    end
    issue(32'd99, 32'h87654321);
    drain(1'b0);

    // Reset in the middle of an operation discards the result
    issue(32'h00ABCDEF, 32'h40000003);
    repeat (14) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    q.delete();
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_Y", Y, 64'd0);
    chk("midrst_Vt", 64'(Vt), 64'd0);
    reset = 1'b1;
    repeat (50) @(negedge clk);
    chk("midrst_idle_busy", 64'(busy), 64'd0);

    issue(32'hFFFFFFF9, 32'd3);
    drain(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
